uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter clk_freq, default 1000000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter baud_rate, default 9600, meaning the serial bit rate in bits/s.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port tx_start, input, 1 bit, a request to send tx_data; it is sampled only in IDLE.
REQ-006 The block SHALL have port tx_data, input, 8 bits, the byte to transmit; it is captured when tx_start is accepted.
REQ-007 The block SHALL have port tx, output, 1 bit, the serial line; it idles high.
REQ-008 The block SHALL have port tx_busy, output, 1 bit, high from the cycle after acceptance through the last stop-bit cycle.
REQ-009 The block SHALL have port done_tx, output, 1 bit, a one-cycle pulse marking frame completion.

Function
REQ-010 The bit period SHALL be N = clk_freq/baud_rate clock cycles, using truncating integer division.
REQ-011 Elaboration SHALL fail if N < 2.
REQ-012 Timing SHALL come from a cycle counter in the clk domain; no derived or divided clock SHALL be generated.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP, plus PARITY when it is enabled.
REQ-014 IDLE with tx_start=1 at cycle t: tx_data SHALL be latched into a shift register, the bit index cleared, and the next state set to START.
REQ-015 START: tx=0 for cycles t+1..t+N, then DATA.
REQ-016 DATA: bit i (i=0..7, LSB first) SHALL drive tx for cycles t+1+(i+1)N .. t+(i+2)N; after bit 7 the FSM goes to STOP (or PARITY when enabled).
REQ-017 STOP: tx=1 for exactly N cycles, then IDLE.
REQ-018 done_tx SHALL be 1 only in the first IDLE cycle after STOP, i.e. cycle t+10N+1 for a 10-bit frame; it is 0 at all other times.
REQ-019 A tx_start in that done_tx cycle SHALL be accepted, allowing back-to-back frames with no extra idle bit.
REQ-020 tx_start while not in IDLE SHALL be ignored; it is not queued.
REQ-021 Changes to tx_data after acceptance SHALL NOT affect the frame in flight.
REQ-022 tx SHALL be driven from a register and SHALL be glitch-free; it changes only on bit-period boundaries.
REQ-023 An illegal state encoding SHALL return to IDLE on the next cycle with tx=1.
REQ-024 The bit index SHALL be 3 bits and SHALL wrap to 0 on leaving DATA.

Reset
REQ-025 rst=1 SHALL, at the next clk edge, force: state=IDLE, tx=1, tx_busy=0, done_tx=0, cycle counter=0, bit index=0, shift register=8'h00.
REQ-026 Reset mid-frame SHALL abort the frame immediately: tx=1 on the next cycle and no done_tx pulse.
REQ-027 tx_start asserted together with rst SHALL be ignored.
REQ-028 The first tx_start after reset is released SHALL be accepted.

Configuration
REQ-029 Macro UART_TX_PARITY_EN, when defined, SHALL insert a PARITY state between DATA and STOP.
REQ-030 With UART_TX_PARITY_EN, the PARITY state SHALL drive tx = XOR of the 8 latched bits (even parity) for N cycles.
REQ-031 With UART_TX_PARITY_EN, the frame SHALL be 11 bits, with done_tx at t+11N+1.
REQ-032 Without UART_TX_PARITY_EN, the frame SHALL be 10 bits (8N1) and no PARITY state or logic SHALL exist.

Verification (clk_freq=80, baud_rate=10, so N=8)
REQ-033 Bench SHALL cover: reset held 3 cycles, then released -> tx=1, tx_busy=0, done_tx=0 throughout and after reset.
REQ-034 Bench SHALL cover: tx_data=8'hA5, tx_start pulse at t -> tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit lasting 8 cycles; done_tx=1 only at t+81.
REQ-035 Bench SHALL cover: 8'h3C, then 8'hC3 with tx_start held in the done_tx cycle -> second start bit begins at t+82 and both bytes are decoded correctly.
REQ-036 Bench SHALL cover: tx_start re-pulsed and tx_data changed to 8'hFF at t+20 during an 8'h00 frame -> frame is still 8'h00 and only one done_tx pulse occurs.
REQ-037 Bench SHALL cover: rst asserted at t+40 mid-frame -> tx=1 from t+41, tx_busy=0, no done_tx pulse; the next frame is sent correctly.
REQ-038 Bench SHALL cover, with UART_TX_PARITY_EN defined: 8'h07 -> parity bit 1 in cycles t+73..t+80, stop bit in t+81..t+88, done_tx at t+89.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter (8N1), bit timing from a cycle counter in the clk domain.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx #(
  parameter int unsigned clk_freq  = 1000000,
  parameter int unsigned baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       done_tx
);

  localparam int unsigned N     = clk_freq / baud_rate;
  localparam int unsigned CNT_W = ($clog2(N) < 1) ? 1 : $clog2(N);

  if (N < 2) begin : g_bad_rate
    $error("uart_tx: clk_freq/baud_rate must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_last;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign cnt_last = (cnt_q == CNT_W'(N - 1));

  // Next-state and registered-output values; tx only moves on bit-period boundaries.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (tx_start) begin
          shift_d  = tx_data;
          idx_d    = 3'd0;
          state_d  = START;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = 3'd0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign done_tx = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: the driver queues expected bytes, a line monitor decodes every cycle.
// Honours UART_TX_PARITY_EN for the 11-bit frame.
module tb_uart_tx;

  localparam int CLK_FREQ = 80;
  localparam int BAUD     = 10;
  localparam int N        = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int L = 11;
`else
  localparam int L = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;
  logic       done_tx;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         free_cyc = 0;
  int         n_expected = 0;
  int         n_done = 0;
  logic [7:0] exp_q[$];

  bit         mon_active = 1'b0;
  bit         prev_rst = 1'b1;
  int         fs = 0;
  int         k = 0;
  logic [7:0] cur_b = 8'h00;

  uart_tx #(
    .clk_freq (CLK_FREQ),
    .baud_rate(BAUD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (tx),
    .tx_busy (tx_busy),
    .done_tx (done_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // Frame bit j of byte b: start, 8 data LSB first, optional even parity, stop.
  function automatic logic model_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return ((int'(b) >> (j - 1)) % 2) == 1;
    if (j == L - 1) return 1'b1;
    return ($countones(b) % 2) == 1;
  endfunction

  // Line monitor: every cycle's tx/tx_busy/done_tx is held against the decoded frame position.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (prev_rst) begin
        chk1("reset_tx", tx, 1'b1);
        chk1("reset_busy", tx_busy, 1'b0);
        chk1("reset_done", done_tx, 1'b0);
        mon_active = 1'b0;
      end else if (mon_active) begin
        k = cyc - fs;
        if (k < L * N) begin
          chk1("frame_bit", tx, model_bit(cur_b, k / N));
          chk1("frame_busy", tx_busy, 1'b1);
          chk1("frame_no_done", done_tx, 1'b0);
        end else begin
          chk1("done_pulse", done_tx, 1'b1);
          chk1("done_tx_high", tx, 1'b1);
          chk1("done_busy_low", tx_busy, 1'b0);
          n_done++;
          mon_active = 1'b0;
        end
      end else if (tx === 1'b0) begin
        chk1("frame_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          cur_b      = exp_q.pop_front();
          fs         = cyc;
          mon_active = 1'b1;
          chk1("start_busy", tx_busy, 1'b1);
          chk1("start_no_done", done_tx, 1'b0);
        end
      end else begin
        chk1("idle_tx", tx, 1'b1);
        chk1("idle_busy", tx_busy, 1'b0);
        chk1("idle_done", done_tx, 1'b0);
      end
    end
    prev_rst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tx_start = 1'b0;
      tx_data  = 8'($urandom);
      tick();
    end
  endtask

  // mode 0: plain frame; 1: stray start + 8'hFF at t+20; 2: reset at t+40; 3: random stray starts
  task automatic send(input logic [7:0] b, input int mode);
    int t;
    t        = cyc;
    tx_start = 1'b1;
    tx_data  = b;
    exp_q.push_back(b);
    if (mode != 2) n_expected++;
    free_cyc = t + L * N + 1;
    tick();
    while (cyc < free_cyc) begin
      tx_start = 1'b0;
      tx_data  = 8'($urandom);
      if (mode == 1 && cyc == t + 20) begin
        tx_start = 1'b1;
        tx_data  = 8'hFF;
      end
      if (mode == 3) tx_start = 1'($urandom_range(0, 1));
      if (mode == 2 && cyc == t + 40) begin
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        free_cyc = cyc;
      end else begin
        tick();
      end
    end
    tx_start = 1'b0;
  endtask

  initial begin
    int guard;
    rst      = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'h5A;
    repeat (3) tick();
    rst      = 1'b0;
    tx_start = 1'b0;
    idle(4);

    send(8'hA5, 0);
    idle(3);
    send(8'h3C, 0);
    send(8'hC3, 0);
    idle(2);
    send(8'h00, 1);
    idle(1);
    send(8'h96, 2);
    send(8'h5B, 0);
    idle(1);
    send(8'h07, 0);
    idle(2);
    repeat (12) begin
      send(8'($urandom), ($urandom_range(0, 1) == 1) ? 3 : 0);
      idle($urandom_range(0, 3));
    end

    guard = 0;
    while ((mon_active || exp_q.size() != 0) && guard < 4 * L * N) begin
      idle(1);
      guard++;
    end
    idle(2);
    chk1("drain_idle", mon_active || (exp_q.size() != 0), 1'b0);
    chk32("frame_count", n_done, n_expected);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
